// File: rtl/keyboard_arrow_decoder_if.sv
// keyboard_arrow_decoder_if
//   Connects a PS/2 byte receiver to the arrow-key decoder.
//   Byte stream (from the receiver):
//     din_new      one-cycle strobe, din holds a complete scan-code byte
//     din[7:0]     scan-code byte, meaningful only while din_new=1
//   Decoded key state (from the decoder):
//     leftPressed / rightPressed / upPressed / downPressed  level flags
//     seqError     one-cycle pulse when a truncated prefix sequence times out
//   Modports: master = byte source, slave = decoder.
interface keyboard_arrow_decoder_if;
  logic       din_new;
  logic [7:0] din;
  logic       leftPressed;
  logic       rightPressed;
  logic       upPressed;
  logic       downPressed;
  logic       seqError;

  modport master (
    output din_new, din,
    input  leftPressed, rightPressed, upPressed, downPressed, seqError
  );

  modport slave (
    input  din_new, din,
    output leftPressed, rightPressed, upPressed, downPressed, seqError
  );
endinterface

// File: rtl/keyboard_arrow_decoder.sv
// keyboard_arrow_decoder
//   Turns a PS/2 Set 2 scan-code byte stream into four level-type arrow
//   flags. Follows E0 (extended) / F0 (break) prefixes, swallows the 8-byte
//   Pause sequence (E1 ...), and drops a dangling prefix after
//   TIMEOUT_CYCLES clocks without a new byte.
//   Parameters:
//     TIMEOUT_CYCLES  clocks of silence before a pending prefix is dropped
//     ACCEPT_KEYPAD   1 = non-extended keypad 8/4/6/2 also drive the flags
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     kbd    slave side of keyboard_arrow_decoder_if (byte in, flags out)
module keyboard_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit ACCEPT_KEYPAD  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  keyboard_arrow_decoder_if.slave  kbd
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // Flag index: 0 = left, 1 = right, 2 = up, 3 = down.
  localparam logic [31:0] KEY_CODES = {8'h72, 8'h75, 8'h74, 8'h6B};

  // Bytes still to discard after the leading E1 of a Pause sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } stateT;

  stateT            stateReg, stateNext;
  logic [2:0]       skipCntReg, skipCntNext;
  logic [CNT_W-1:0] timeoutCntReg, timeoutCntNext;
  logic [3:0]       flagsReg, flagsNext;
  logic             seqErrorReg, seqErrorNext;

  logic [3:0] keyHit;
  logic       isPrefix;
  logic       timeoutHit;
  logic       makeEv;
  logic       breakEv;
  logic       extEv;
  logic       applyEv;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gKeyMatch
      assign keyHit[gi] = (kbd.din == KEY_CODES[8*gi +: 8]);
    end
  endgenerate

  assign isPrefix = (kbd.din == CODE_EXT) || (kbd.din == CODE_BREAK) ||
                    (kbd.din == CODE_PAUSE);

  // An arriving byte always beats an expiring timeout.
  assign timeoutHit = (stateReg != IDLE) && !kbd.din_new &&
                      (timeoutCntReg == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      skipCntReg    <= 3'd0;
      timeoutCntReg <= '0;
      flagsReg      <= 4'b0000;
      seqErrorReg   <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      skipCntReg    <= skipCntNext;
      timeoutCntReg <= timeoutCntNext;
      flagsReg      <= flagsNext;
      seqErrorReg   <= seqErrorNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext   = stateReg;
    skipCntNext = skipCntReg;
    if (kbd.din_new) begin
      case (stateReg)
        IDLE: begin
          if (kbd.din == CODE_EXT) begin
            stateNext = EXT;
          end else if (kbd.din == CODE_BREAK) begin
            stateNext = BRK;
          end else if (kbd.din == CODE_PAUSE) begin
            stateNext   = SKIP;
            skipCntNext = PAUSE_TAIL;
          end
        end
        EXT: begin
          if (kbd.din == CODE_BREAK) begin
            stateNext = EXT_BRK;
          end else if (kbd.din == CODE_EXT) begin
            stateNext = EXT;
          end else if (kbd.din == CODE_PAUSE) begin
            stateNext   = SKIP;
            skipCntNext = PAUSE_TAIL;
          end else begin
            stateNext = IDLE;
          end
        end
        BRK, EXT_BRK: stateNext = IDLE;
        SKIP: begin
          // A zero count here is unreachable; leave SKIP rather than wrap.
          if (skipCntReg != 3'd0) begin
            skipCntNext = skipCntReg - 3'd1;
          end
          if (skipCntReg <= 3'd1) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (timeoutHit) begin
      stateNext   = IDLE;
      skipCntNext = 3'd0;
    end

    // Stops at TIMEOUT_LAST because timeoutHit clears it, so it cannot wrap.
    if (kbd.din_new || timeoutHit) begin
      timeoutCntNext = '0;
    end else if (stateReg != IDLE) begin
      timeoutCntNext = timeoutCntReg + 1'b1;
    end else begin
      timeoutCntNext = timeoutCntReg;
    end
  end

  // Output logic: classify the byte as make/break and update flags.
  always_comb begin
    makeEv       = 1'b0;
    breakEv      = 1'b0;
    extEv        = 1'b0;
    seqErrorNext = timeoutHit;
    if (kbd.din_new) begin
      case (stateReg)
        IDLE:    makeEv = !isPrefix;
        EXT: begin
          makeEv = !isPrefix;
          extEv  = 1'b1;
        end
        // After F0 every byte, prefix values included, is a break code.
        BRK:     breakEv = 1'b1;
        EXT_BRK: begin
          breakEv = 1'b1;
          extEv   = 1'b1;
        end
        default: ;
      endcase
    end
    applyEv = (makeEv || breakEv) && (extEv || ACCEPT_KEYPAD);
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : gFlagNext
      assign flagsNext[gi] = (applyEv && keyHit[gi]) ? makeEv : flagsReg[gi];
    end
  endgenerate

  assign kbd.leftPressed  = flagsReg[0];
  assign kbd.rightPressed = flagsReg[1];
  assign kbd.upPressed    = flagsReg[2];
  assign kbd.downPressed  = flagsReg[3];
  assign kbd.seqError     = seqErrorReg;

endmodule
